// File: rtl/ntt_scheduler.sv
// ---------------------------------------------------------------------------
// ntt_scheduler
//
// Two-requester front end for a pair of NTT engines (forward and inverse).
// One operation is in flight at a time: a requester is granted in IDLE, the
// selected engine gets a one-cycle start pulse, the scheduler waits for a
// rising edge on that engine's done level (or a timeout), then reports the
// result with a one-cycle completion strobe. Contention between requesters
// is resolved round-robin.
//
// Parameters
//   TIMEOUT        max WAIT cycles before the operation is aborted (>= 2)
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   req_valid[1:0] per-requester request (held until accepted)
//   req_op[1:0]    per-requester op: 0 = forward NTT, 1 = inverse NTT
//   req_ready[1:0] per-requester accept strobe (combinational, IDLE only)
//   ntt_start      one-cycle start pulse, forward engine
//   ntt_done       completion level, forward engine
//   ntt_inv_start  one-cycle start pulse, inverse engine
//   ntt_inv_done   completion level, inverse engine
//   cmp_valid      one-cycle completion strobe
//   cmp_id         requester index of the completed operation
//   cmp_op         op of the completed operation
//   cmp_err        1 = operation timed out (valid with cmp_valid)
//   busy           high whenever the scheduler is not IDLE
// ---------------------------------------------------------------------------
module ntt_scheduler #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_op,
    output logic [1:0] req_ready,
    output logic       ntt_start,
    input  logic       ntt_done,
    output logic       ntt_inv_start,
    input  logic       ntt_inv_done,
    output logic       cmp_valid,
    output logic       cmp_id,
    output logic       cmp_op,
    output logic       cmp_err,
    output logic       busy
);

    localparam int            TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        CMPL  = 2'd3
    } state_t;

    state_t        state_q;
    logic          rr_ptr_q;
    logic [TW-1:0] timer_q;
    logic          id_q;
    logic          op_q;
    logic          fwd_done_prev_q;
    logic          inv_done_prev_q;
    logic          ntt_start_q;
    logic          ntt_inv_start_q;
    logic          cmp_valid_q;
    logic          cmp_id_q;
    logic          cmp_op_q;
    logic          cmp_err_q;

    logic          grant_id_d;
    logic [1:0]    req_ready_d;
    logic          accept;
    logic          done_edge;

    // Arbitration: a lone requester always wins; on contention rr_ptr picks.
    // req_ready is gated by reset so nothing is offered while reset is held.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_id_d  = 1'b0;
        req_ready_d = 2'b00;
        case (req_valid)
            2'b10:   grant_id_d = 1'b1;
            2'b11:   grant_id_d = rr_ptr_q;
            default: grant_id_d = 1'b0;
        endcase
        if (state_q == IDLE && !reset && req_valid != 2'b00) begin
            req_ready_d = grant_id_d ? 2'b10 : 2'b01;
        end
    end

    assign accept = |(req_valid & req_ready_d);

    // Only the engine chosen by the latched op can complete the operation;
    // a level that was already high on the previous cycle is not an edge.
    assign done_edge = op_q ? (ntt_inv_done & ~inv_done_prev_q)
                            : (ntt_done     & ~fwd_done_prev_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every register here is control state, so all of them are
            // cleared by the asynchronous reset; an aborted operation leaves
            // nothing behind that could restart or report it.
            state_q         <= IDLE;
            rr_ptr_q        <= 1'b0;
            timer_q         <= '0;
            id_q            <= 1'b0;
            op_q            <= 1'b0;
            fwd_done_prev_q <= 1'b0;
            inv_done_prev_q <= 1'b0;
            ntt_start_q     <= 1'b0;
            ntt_inv_start_q <= 1'b0;
            cmp_valid_q     <= 1'b0;
            cmp_id_q        <= 1'b0;
            cmp_op_q        <= 1'b0;
            cmp_err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values regardless of statement order.
            fwd_done_prev_q <= ntt_done;
            inv_done_prev_q <= ntt_inv_done;

            // Pulse outputs default low; the transitions below raise them
            // for exactly the one cycle they belong to.
            ntt_start_q     <= 1'b0;
            ntt_inv_start_q <= 1'b0;
            cmp_valid_q     <= 1'b0;
            cmp_id_q        <= 1'b0;
            cmp_op_q        <= 1'b0;
            cmp_err_q       <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q            <= grant_id_d;
                        op_q            <= req_op[grant_id_d];
                        ntt_start_q     <= ~req_op[grant_id_d];
                        ntt_inv_start_q <= req_op[grant_id_d];
                        state_q         <= START;
                    end
                end

                START: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    timer_q <= timer_q + TW'(1);
                    // Completion is tested first so it wins over a timeout
                    // landing in the same cycle.
                    if (done_edge) begin
                        cmp_valid_q <= 1'b1;
                        cmp_id_q    <= id_q;
                        cmp_op_q    <= op_q;
                        cmp_err_q   <= 1'b0;
                        state_q     <= CMPL;
                    end else if (timer_q == TIMER_LAST) begin
                        cmp_valid_q <= 1'b1;
                        cmp_id_q    <= id_q;
                        cmp_op_q    <= op_q;
                        cmp_err_q   <= 1'b1;
                        state_q     <= CMPL;
                    end
                end

                CMPL: begin
                    // Point at the other requester so it wins the next tie.
                    rr_ptr_q <= ~id_q;
                    state_q  <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_d;
    assign ntt_start     = ntt_start_q;
    assign ntt_inv_start = ntt_inv_start_q;
    assign cmp_valid     = cmp_valid_q;
    assign cmp_id        = cmp_id_q;
    assign cmp_op        = cmp_op_q;
    assign cmp_err       = cmp_err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/ntt_scheduler.md
NTT_SCHEDULER -- requirements
Module: ntt_scheduler

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 1024, the maximum number of WAIT cycles before an operation is aborted; legal values are 2 or more.
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL provide port req_valid, input, 2 bits, per-requester request; bit i belongs to requester i.
REQ-005 SHALL provide port req_op, input, 2 bits, per-requester operation: bit i = 0 for forward NTT, 1 for inverse NTT.
REQ-006 SHALL provide port req_ready, output, 2 bits, per-requester accept strobe.
REQ-007 SHALL provide port ntt_start, output, 1 bit, start pulse to the forward NTT engine.
REQ-008 SHALL provide port ntt_done, input, 1 bit, completion level from the forward NTT engine, synchronous to clk.
REQ-009 SHALL provide port ntt_inv_start, output, 1 bit, start pulse to the inverse NTT engine.
REQ-010 SHALL provide port ntt_inv_done, input, 1 bit, completion level from the inverse NTT engine, synchronous to clk.
REQ-011 SHALL provide port cmp_valid, output, 1 bit, one-cycle completion strobe.
REQ-012 SHALL provide port cmp_id, output, 1 bit, requester index of the completed operation.
REQ-013 SHALL provide port cmp_op, output, 1 bit, operation type of the completed operation.
REQ-014 SHALL provide port cmp_err, output, 1 bit, timeout flag; valid only while cmp_valid is high.
REQ-015 SHALL provide port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT and CMPL.
REQ-017 IDLE: when any req_valid bit is high, SHALL grant exactly one requester and hold req_ready high for that requester only, combinationally, in the same cycle.
REQ-018 Acceptance occurs when req_valid[i] and req_ready[i] are both high; on acceptance SHALL latch the id and req_op[i], then move to START.
REQ-019 Arbitration: if only one requester is valid, SHALL grant it; if both are valid, SHALL grant the requester pointed to by rr_ptr.
REQ-020 rr_ptr SHALL reset to 0 and, in CMPL, SHALL be set to the inverse of the completed id.
REQ-021 START: SHALL assert ntt_start (op = 0) or ntt_inv_start (op = 1) high for exactly one cycle, clear the timer, and move to WAIT.
REQ-022 SHALL register the previous value of each done input; a completion is a rising edge (current high, registered previous low) seen in WAIT on the engine selected by the latched op.
REQ-023 A done level that is already high when WAIT is entered SHALL NOT count as a completion.
REQ-024 A done edge from the engine that was not selected SHALL be ignored.
REQ-025 WAIT: the timer SHALL increment once per cycle, with width $clog2(TIMEOUT)+1 bits.
REQ-026 WAIT: on a completion edge SHALL go to CMPL with error = 0.
REQ-027 WAIT: if the timer equals TIMEOUT-1 with no completion edge, SHALL go to CMPL with error = 1.
REQ-028 If a completion edge and the timeout occur in the same cycle, completion SHALL win and error SHALL be 0.
REQ-029 CMPL: SHALL hold cmp_valid high for exactly one cycle with cmp_id, cmp_op and cmp_err taken from the latched values, then return to IDLE.
REQ-030 Latency: acceptance in cycle N gives the start pulse in cycle N+1; a completion edge in cycle M gives cmp_valid in cycle M+1; the next acceptance is possible no earlier than M+2.
REQ-031 req_ready SHALL be 0 in every state except IDLE.
REQ-032 Requests arriving while busy SHALL be held off; there SHALL be no queueing and no loss, because requesters hold req_valid until accepted.
REQ-033 A change in req_op after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-034 On reset assertion, at any time including mid-WAIT, SHALL enter IDLE asynchronously and clear rr_ptr, timer, the latched id and op, and the done-history registers.
REQ-035 While reset is asserted and immediately after it, outputs req_ready, ntt_start, ntt_inv_start, cmp_valid, cmp_id, cmp_op, cmp_err and busy SHALL all be 0.
REQ-036 After reset, an aborted operation SHALL NOT be restarted or reported.

Verification
REQ-037 Single request: req_valid=01, req_op=00 -> req_ready=01 in the same cycle; ntt_start high for 1 cycle at N+1; ntt_done rises 30 cycles later -> cmp_valid=1, cmp_id=0, cmp_op=0, cmp_err=0 in the next cycle.
REQ-038 Contention: req_valid=11 held continuously after reset -> grant order 0, 1, 0; req_op=10 produces ntt_start, then ntt_inv_start, then ntt_start.
REQ-039 Timeout: TIMEOUT=16, request with no done -> cmp_valid=1 with cmp_err=1 exactly 17 cycles after the start pulse; busy=0 on the following cycle.
REQ-040 Stale and wrong done: ntt_done held high before a forward request -> no completion until it falls and rises again; during an inverse op, an ntt_done pulse is ignored and only ntt_inv_done completes it.
REQ-041 Simultaneous edge: the done edge lands in the cycle the timer reaches TIMEOUT-1 -> cmp_err=0.
REQ-042 Reset mid-WAIT: all outputs go to 0 immediately; no cmp_valid is produced; a new req_valid=10 request is then served normally, granting requester 1.
